// File: rtl/ir_seq.sv
// ir_seq: IR line-sensor sweep sequencer sharing one SPI A2D master.
// Ports: clk, rst_n | wrt, cmd, done, rd_data (SPI handshake) | IR_en,
//   IR_vld, line_present, spi_err, IR_R0..IR_R3, IR_L0..IR_L3 (results).
module ir_seq #(
   parameter int          FAST_SIM   = 1,
   parameter logic [11:0] LINE_THRES = 12'h200
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        wrt,
   output logic [15:0] cmd,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic        IR_en,
   output logic        IR_vld,
   output logic        line_present,
   output logic        spi_err,
   output logic [11:0] IR_R0,
   output logic [11:0] IR_R1,
   output logic [11:0] IR_R2,
   output logic [11:0] IR_R3,
   output logic [11:0] IR_L0,
   output logic [11:0] IR_L1,
   output logic [11:0] IR_L2,
   output logic [11:0] IR_L3
);

   localparam int PER_BITS   = (FAST_SIM != 0) ? 12 : 20;
   localparam int SETTLE_CYC = (FAST_SIM != 0) ? 256 : 2048;
   localparam int TIMEOUT    = 1024;

   localparam logic [10:0] SETTLE_LAST = 11'(SETTLE_CYC - 1);
   localparam logic [10:0] TMO_LAST    = 11'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      XFER,
      WAIT,
      PUBLISH
   } state_t;

   state_t      state;
   state_t      nxt;
   logic [19:0] per_cnt;
   logic        tick;
   logic [10:0] cnt;
   logic [2:0]  chnl;
   logic [11:0] stg [8];
   logic [11:0] pub [8];

   logic cnt_clr;
   logic cnt_inc;
   logic chnl_inc;
   logic stg_ld;
   logic en_set;
   logic en_clr;
   logic pub_ld;
   logic any_line;
   logic unused_bits;

   // Period tick; ticks arriving outside IDLE are simply not acted on.
   assign tick = &per_cnt[PER_BITS-1:0];

   // Upper nibble of the A2D word carries no conversion data.
   assign unused_bits = ^rd_data[15:12];

   assign cmd = wrt ? {2'b00, chnl, 11'h000} : 16'h0000;

   assign IR_R0 = pub[0];
   assign IR_R1 = pub[1];
   assign IR_R2 = pub[2];
   assign IR_R3 = pub[3];
   assign IR_L0 = pub[4];
   assign IR_L1 = pub[5];
   assign IR_L2 = pub[6];
   assign IR_L3 = pub[7];

   always_comb begin
      any_line = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (stg[i] > LINE_THRES) begin
            any_line = 1'b1;
         end
      end
   end

   always_comb begin
      nxt      = state;
      wrt      = 1'b0;
      spi_err  = 1'b0;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      chnl_inc = 1'b0;
      stg_ld   = 1'b0;
      en_set   = 1'b0;
      en_clr   = 1'b0;
      pub_ld   = 1'b0;
      unique case (state)
         IDLE: begin
            if (tick) begin
               nxt     = SETTLE;
               en_set  = 1'b1;
               cnt_clr = 1'b1;
            end
         end
         SETTLE: begin
            if (cnt == SETTLE_LAST) begin
               nxt = XFER;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         XFER: begin
            wrt     = 1'b1;
            cnt_clr = 1'b1;
            nxt     = WAIT;
         end
         WAIT: begin
            // done wins over a timeout expiring in the same cycle
            if (done) begin
               stg_ld = 1'b1;
               if (chnl == 3'd7) begin
                  nxt = PUBLISH;
               end else begin
                  chnl_inc = 1'b1;
                  nxt      = XFER;
               end
            end else if (cnt == TMO_LAST) begin
               spi_err = 1'b1;
               en_clr  = 1'b1;
               nxt     = IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         PUBLISH: begin
            pub_ld = 1'b1;
            en_clr = 1'b1;
            nxt    = IDLE;
         end
         default: begin
            nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         per_cnt      <= '0;
         cnt          <= '0;
         chnl         <= '0;
         IR_en        <= 1'b0;
         IR_vld       <= 1'b0;
         line_present <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            stg[i] <= '0;
            pub[i] <= '0;
         end
      end else begin
         state   <= nxt;
         per_cnt <= per_cnt + 20'd1;
         IR_vld  <= pub_ld;
         if (cnt_clr) begin
            cnt <= '0;
         end else if (cnt_inc) begin
            cnt <= cnt + 11'd1;
         end
         if (en_set) begin
            chnl <= '0;
         end else if (chnl_inc) begin
            chnl <= chnl + 3'd1;
         end
         if (en_set) begin
            IR_en <= 1'b1;
         end else if (en_clr) begin
            IR_en <= 1'b0;
         end
         if (stg_ld) begin
            stg[chnl] <= rd_data[11:0];
         end
         // whole set moves at once so outputs never show a partial sweep
         if (pub_ld) begin
            for (int i = 0; i < 8; i++) begin
               pub[i] <= stg[i];
            end
            line_present <= any_line;
         end
      end
   end

endmodule
